// File: rtl/hash_drbg_stream_ctrl.sv
// Hash-DRBG control core: sequences an external hash core, keeps V, slices digests into a stream.
// Optional continuous digest health test is enabled by defining DRBG_HEALTH_TEST_EN.
module hash_drbg_stream_ctrl #(
    parameter int DIGEST_WIDTH  = 256,
    parameter int OUT_WIDTH     = 32,
    parameter int BITS_PER_SEED = 3,
    parameter int SEED_MAX      = 3,
    parameter int CNT_WIDTH     = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    is_master_mode,
    input  logic                    init,
    input  logic [DIGEST_WIDTH-1:0] entropy,
    input  logic                    next_seed,
    output logic                    hash_start,
    output logic [DIGEST_WIDTH-1:0] hash_msg,
    input  logic                    hash_done,
    input  logic [DIGEST_WIDTH-1:0] hash_digest,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    init_ready,
    output logic [CNT_WIDTH-1:0]    reseed_counter,
    output logic                    seed_overrun,
    output logic                    fault
);
    // state       | meaning
    // IDLE        | unseeded, waiting for init
    // INIT_HASH   | hashing entropy into the first V
    // GEN_HASH    | hashing V+gen_index into D
    // EMIT        | streaming D out one slice per handshake
    // RESEED_CHK  | decide between exhaustion, reseed, or waiting
    // RESEED_WAIT | slave mode, waiting for next_seed
    // RESEED_HASH | hashing V^D into the next V
    // EXHAUSTED   | seed budget used (or health fault), waiting for init

    localparam int NW = DIGEST_WIDTH / OUT_WIDTH;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int GW = $clog2(BITS_PER_SEED + 1);

    if (DIGEST_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
        $error("DIGEST_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (BITS_PER_SEED < 1 || SEED_MAX < 1) begin : g_bad_counts
        $error("BITS_PER_SEED and SEED_MAX must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE, INIT_HASH, GEN_HASH, EMIT, RESEED_CHK, RESEED_WAIT, RESEED_HASH, EXHAUSTED
    } state_t;

    state_t                  state, state_next;
    logic [DIGEST_WIDTH-1:0] v, d, msg_next;
    logic [GW-1:0]           gen_index, gen_inc;
    logic [WW-1:0]           word_idx;
    logic                    pending;
    logic                    hashing, digest_in, digest_fail, last_word, accept, launch;
    logic [OUT_WIDTH-1:0]    slices [NW];

    for (genvar i = 0; i < NW; i++) begin : g_slice
        assign slices[i] = d[i*OUT_WIDTH +: OUT_WIDTH];
    end

    assign hashing   = (state == INIT_HASH) || (state == GEN_HASH) || (state == RESEED_HASH);
    assign digest_in = hashing && hash_done;
    assign gen_inc   = gen_index + 1'b1;
    assign last_word = (word_idx == WW'(NW - 1));
    assign accept    = (state == EMIT) && out_ready;

`ifdef DRBG_HEALTH_TEST_EN
    logic [DIGEST_WIDTH-1:0] prev_digest;
    logic                    prev_valid;
    logic                    fault_q;

    assign digest_fail = prev_valid && (hash_digest == prev_digest);
    assign fault       = fault_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_digest <= '0;
            prev_valid  <= 1'b0;
            fault_q     <= 1'b0;
        end else if ((state == IDLE || state == EXHAUSTED) && init) begin
            prev_valid <= 1'b0;
            fault_q    <= 1'b0;
        end else if (digest_in) begin
            prev_digest <= hash_digest;
            prev_valid  <= 1'b1;
            if (digest_fail) fault_q <= 1'b1;
        end
    end
`else
    assign digest_fail = 1'b0;
    assign fault       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, EXHAUSTED: if (init) state_next = INIT_HASH;
            INIT_HASH, RESEED_HASH:
                if (hash_done) state_next = digest_fail ? EXHAUSTED : GEN_HASH;
            GEN_HASH:
                if (hash_done) state_next = digest_fail ? EXHAUSTED : EMIT;
            EMIT:
                if (out_ready && last_word)
                    state_next = (gen_inc < GW'(BITS_PER_SEED)) ? GEN_HASH : RESEED_CHK;
            RESEED_CHK: begin
                if (reseed_counter == CNT_WIDTH'(SEED_MAX)) state_next = EXHAUSTED;
                else if (is_master_mode || pending)         state_next = RESEED_HASH;
                else                                        state_next = RESEED_WAIT;
            end
            RESEED_WAIT: if (next_seed) state_next = RESEED_HASH;
            default:     state_next = IDLE;
        endcase
    end

    // Any move into a hashing state launches the hash core with the message for that state.
    always_comb begin
        launch = (state_next != state) &&
                 (state_next == INIT_HASH || state_next == GEN_HASH || state_next == RESEED_HASH);
        case (state_next)
            INIT_HASH:   msg_next = entropy;
            GEN_HASH:    msg_next = (state == EMIT) ? v + DIGEST_WIDTH'(gen_inc) : hash_digest;
            RESEED_HASH: msg_next = v ^ d;
            default:     msg_next = hash_msg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v              <= '0;
            d              <= '0;
            gen_index      <= '0;
            word_idx       <= '0;
            pending        <= 1'b0;
            seed_overrun   <= 1'b0;
            reseed_counter <= '0;
            hash_msg       <= '0;
            hash_start     <= 1'b0;
        end else begin
            hash_start <= launch;
            if (launch) hash_msg <= msg_next;

            if (next_seed && !is_master_mode && state != IDLE && state != EXHAUSTED &&
                state != RESEED_WAIT && state != RESEED_CHK) begin
                if (pending) seed_overrun <= 1'b1;
                pending <= 1'b1;
            end

            case (state)
                INIT_HASH: if (hash_done) begin
                    v              <= hash_digest;
                    reseed_counter <= CNT_WIDTH'(1);
                    gen_index      <= '0;
                    pending        <= 1'b0;
                    seed_overrun   <= 1'b0;
                end
                GEN_HASH: if (hash_done) begin
                    d        <= hash_digest;
                    word_idx <= '0;
                end
                EMIT: if (accept) begin
                    if (last_word) begin
                        word_idx  <= '0;
                        gen_index <= gen_inc;
                    end else begin
                        word_idx <= word_idx + 1'b1;
                    end
                end
                RESEED_CHK:
                    if (state_next == RESEED_HASH && !is_master_mode) pending <= 1'b0;
                RESEED_HASH: if (hash_done) begin
                    v         <= hash_digest;
                    gen_index <= '0;
                    if (reseed_counter != '1) reseed_counter <= reseed_counter + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_valid  = (state == EMIT);
        init_ready = (state == GEN_HASH) || (state == EMIT) || (state == RESEED_CHK) ||
                     (state == RESEED_WAIT) || (state == RESEED_HASH);
        out_data   = slices[word_idx];
    end

endmodule

// File: tb/tb_hash_drbg_stream_ctrl.sv
// Scoreboard bench for hash_drbg_stream_ctrl with a digest=msg+1, 4-cycle hash model.
// Define DRBG_HEALTH_TEST_EN to switch the hash model to a constant digest and run the health check.
module tb_hash_drbg_stream_ctrl;
    localparam int DW = 256;
    localparam int OW = 32;
    localparam int NW = DW / OW;
    localparam int BPS = 3;
    localparam int SMAX = 3;
    localparam int TOTAL = NW * BPS * SMAX;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          is_master_mode = 1'b1;
    logic          init = 1'b0;
    logic [DW-1:0] entropy = '0;
    logic          next_seed = 1'b0;
    logic          hash_start;
    logic [DW-1:0] hash_msg;
    logic          hash_done = 1'b0;
    logic [DW-1:0] hash_digest = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          init_ready;
    logic [63:0]   reseed_counter;
    logic          seed_overrun;
    logic          fault;

    int tests = 0;
    int fails = 0;
    int word_cnt = 0;
    int starts = 0;
    bit rand_en = 1'b0;
    bit ready_force = 1'b1;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];

    hash_drbg_stream_ctrl dut (
        .clk(clk), .reset_n(reset_n), .is_master_mode(is_master_mode), .init(init),
        .entropy(entropy), .next_seed(next_seed), .hash_start(hash_start), .hash_msg(hash_msg),
        .hash_done(hash_done), .hash_digest(hash_digest), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .init_ready(init_ready),
        .reseed_counter(reseed_counter), .seed_overrun(seed_overrun), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference: whole keystream of one init, from the DRBG rules with digest = msg + 1.
    task automatic push_expected(input logic [DW-1:0] e);
        logic [DW-1:0] vv, dd;
        vv = e + 1;
        for (int s = 0; s < SMAX; s++) begin
            for (int g = 0; g < BPS; g++) begin
                dd = vv + DW'(g) + 1;
                for (int w = 0; w < NW; w++) exp_q.push_back(dd[w*OW +: OW]);
            end
            vv = (vv ^ dd) + 1;
        end
    endtask

    // Hash core model, deliberately not reset so a stale hash_done can follow a reset.
    initial begin
        logic [DW-1:0] m;
        forever begin
            @(negedge clk);
            if (hash_start) begin
                m = hash_msg;
                repeat (3) @(posedge clk);
                #1;
                hash_done = 1'b1;
`ifdef DRBG_HEALTH_TEST_EN
                hash_digest = DW'(8'hAB);
`else
                hash_digest = m + 1;
`endif
                @(posedge clk);
                #1 hash_done = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1 out_ready = rand_en ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    always @(negedge clk) begin
        if (reset_n && hash_start) starts++;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            word_cnt++;
            got_q.push_back(out_data);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %0h expected no word", out_data);
            end else begin
                chk("stream_word", DW'(out_data), DW'(exp_q.pop_front()));
            end
        end
    end

    task automatic pulse_seed();
        @(posedge clk); #1 next_seed = 1'b1;
        @(posedge clk); #1 next_seed = 1'b0;
    endtask

    task automatic run_init(input logic [DW-1:0] e, input bit master, input bit expect_words);
        is_master_mode = master;
        entropy = e;
        if (expect_words) push_expected(e);
        @(posedge clk); #1 init = 1'b1;
        @(posedge clk); #1 init = 1'b0;
    endtask

    task automatic wait_words(input int target, input int budget, input string name);
        int n = 0;
        while (word_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (word_cnt < target) timeout(name);
    endtask

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout(name);
        repeat (4) @(negedge clk);
        chk({name, "_words"}, DW'(word_cnt - base), DW'(TOTAL));
        chk({name, "_reseed_counter"}, DW'(reseed_counter), DW'(SMAX));
        chk({name, "_init_ready"}, DW'(init_ready), '0);
        chk({name, "_out_valid"}, DW'(out_valid), '0);
        chk({name, "_fault"}, DW'(fault), '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        exp_q.delete();
        rand_en = 1'b0;
        ready_force = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int base, s0, s1, w0, n;
        logic [OW-1:0] held;
        bit bad;

        repeat (3) @(negedge clk);
        chk("rst_hash_start", DW'(hash_start), '0);
        chk("rst_hash_msg", hash_msg, '0);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data", DW'(out_data), '0);
        chk("rst_init_ready", DW'(init_ready), '0);
        chk("rst_reseed_counter", DW'(reseed_counter), '0);
        chk("rst_seed_overrun", DW'(seed_overrun), '0);
        chk("rst_fault", DW'(fault), '0);
        @(posedge clk); #1 reset_n = 1'b1;
        s0 = starts;
        repeat (100) @(negedge clk);
        chk("idle_no_start", DW'(starts - s0), '0);

`ifdef DRBG_HEALTH_TEST_EN
        base = word_cnt;
        run_init('0, 1'b1, 1'b0);
        n = 0;
        while (!fault && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!fault) timeout("health_fault");
        repeat (4) @(negedge clk);
        chk("health_fault", DW'(fault), DW'(1));
        chk("health_words", DW'(word_cnt - base), '0);
        chk("health_init_ready", DW'(init_ready), '0);
        chk("health_out_valid", DW'(out_valid), '0);
`else
        // Master, entropy 0, with a 10-cycle stall mid-digest
        base = word_cnt;
        ready_force = 1'b1;
        run_init('0, 1'b1, 1'b1);
        wait_words(base + 2, 300, "bp_reach");
        ready_force = 1'b0;
        repeat (2) @(negedge clk);
        held = out_data;
        s0 = starts;
        w0 = word_cnt;
        chk("bp_held_is_next", DW'(held), (exp_q.size() != 0) ? DW'(exp_q[0]) : '1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== held) bad = 1'b1;
        end
        chk("bp_stable", DW'(bad), '0);
        chk("bp_no_start", DW'(starts - s0), '0);
        chk("bp_no_words", DW'(word_cnt - w0), '0);
        rand_en = 1'b1;
        wait_done(base, "master0");

        // Master, random entropy
        base = word_cnt;
        run_init({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 1'b1, 1'b1);
        wait_done(base, "master_rand");

        // Slave: stalls after first seed, early pulse avoids the second wait
        base = word_cnt;
        run_init({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 1'b0, 1'b1);
        wait_words(base + NW * BPS, 2000, "slave_seed1");
        repeat (20) @(negedge clk);
        s0 = starts;
        repeat (30) @(negedge clk);
        chk("slave_wait_no_start", DW'(starts - s0), '0);
        chk("slave_wait_init_ready", DW'(init_ready), DW'(1));
        chk("slave_wait_words", DW'(word_cnt - base), DW'(NW * BPS));
        pulse_seed();
        rand_en = 1'b0;
        ready_force = 1'b1;
        wait_words(base + NW * BPS + 2, 300, "slave_seed2");
        pulse_seed();
        rand_en = 1'b1;
        wait_done(base, "slave");
        chk("slave_no_overrun", DW'(seed_overrun), '0);

        // Overrun: two pulses while stalled in EMIT
        rand_en = 1'b0;
        ready_force = 1'b0;
        run_init({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout("overrun_emit");
        chk("overrun_clear_at_init", DW'(seed_overrun), '0);
        pulse_seed();
        pulse_seed();
        @(negedge clk);
        chk("overrun_set", DW'(seed_overrun), DW'(1));
        chk("overrun_init_ready", DW'(init_ready), DW'(1));
        do_reset();
        @(negedge clk);
        chk("overrun_cleared_by_reset", DW'(seed_overrun), '0);

        // Reset during GEN_HASH, stale hash_done afterwards
        s0 = starts;
        run_init('0, 1'b1, 1'b0);
        n = 0;
        while (starts < s0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (starts < s0 + 2) timeout("abort_gen_start");
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        s1 = starts;
        w0 = word_cnt;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || init_ready !== 1'b0) bad = 1'b1;
        end
        chk("abort_quiet", DW'(bad), '0);
        chk("abort_no_start", DW'(starts - s1), '0);
        chk("abort_no_words", DW'(word_cnt - w0), '0);
        chk("abort_reseed_counter", DW'(reseed_counter), '0);
        chk("abort_hash_msg", hash_msg, '0);
        base = word_cnt;
        rand_en = 1'b1;
        run_init('0, 1'b1, 1'b1);
        wait_words(base + 1, 300, "restart_first");
        if (got_q.size() > base) chk("restart_first_word", DW'(got_q[base]), DW'(2));
        wait_done(base, "restart");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "global timeout");
    end

endmodule
